procyon_tag_freelist: RTL and testbench

Circular free-list allocator for the N tags of a renamed resource (ROB, reservation-station, or LSQ entries). Each cycle it offers the oldest free tag in binary form plus a one-hot decode for direct entry-enable fan-out. It accepts at most one allocation and one release per cycle and supports a single-cycle flush back to the all-free state. It sits between dispatch (the allocator) and the entry arrays (the consumers of the one-hot enable).

---
 rtl/procyon_lib_pkg.sv | 9 +
 rtl/procyon_binary2onehot.sv | 22 ++
 rtl/procyon_tag_freelist.sv | 115 +++++++++++
 tb/tb_procyon_tag_freelist.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/procyon_lib_pkg.sv
// Shared helpers for the procyon block library.
// pcyn_c2i: number of bits needed to index `value` items (minimum of 1 bit).
package procyon_lib_pkg;

  function automatic int unsigned pcyn_c2i(input int unsigned value);
    return (value <= 1) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/procyon_binary2onehot.sv
// Binary to one-hot decoder.
// Ports:
//   binary_i : binary index
//   onehot_o : one-hot decode of binary_i; all-zero for indices >= OPTN_ONEHOT_WIDTH
module procyon_binary2onehot
  import procyon_lib_pkg::*;
#(
  parameter int unsigned OPTN_ONEHOT_WIDTH = 8,
  localparam int unsigned BinWidth = pcyn_c2i(OPTN_ONEHOT_WIDTH)
) (
  input  logic [BinWidth-1:0]          binary_i,
  output logic [OPTN_ONEHOT_WIDTH-1:0] onehot_o
);

  always_comb begin
    onehot_o = '0;
    for (int unsigned i = 0; i < OPTN_ONEHOT_WIDTH; i++) begin
      onehot_o[i] = (binary_i == BinWidth'(i));
    end
  end

endmodule

// File: rtl/procyon_tag_freelist.sv
// Circular free-list allocator for the tags of a renamed resource.
// Offers the oldest free tag (binary and one-hot), accepts one allocation and one
// release per cycle, and flushes back to the all-free state in a single cycle.
// Ports:
//   clk, n_rst      : clock, synchronous active-low reset
//   i_flush         : return every tag to the free list (beats alloc/release)
//   i_alloc_en      : consume the offered tag
//   o_alloc_valid   : a free tag is offered
//   o_alloc_tag     : offered tag, binary
//   o_alloc_onehot  : offered tag, one-hot; zero when nothing is offered
//   i_release_en    : return i_release_tag to the list
//   i_release_tag   : tag being returned
//   o_free_count    : number of free tags
//   o_empty         : no free tags
module procyon_tag_freelist
  import procyon_lib_pkg::*;
#(
  parameter int unsigned OPTN_NUM_TAGS = 32,
  localparam int unsigned TAG_WIDTH = pcyn_c2i(OPTN_NUM_TAGS),
  localparam int unsigned CNT_WIDTH = pcyn_c2i(OPTN_NUM_TAGS + 1)
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     i_flush,
  input  logic                     i_alloc_en,
  output logic                     o_alloc_valid,
  output logic [TAG_WIDTH-1:0]     o_alloc_tag,
  output logic [OPTN_NUM_TAGS-1:0] o_alloc_onehot,
  input  logic                     i_release_en,
  input  logic [TAG_WIDTH-1:0]     i_release_tag,
  output logic [CNT_WIDTH-1:0]     o_free_count,
  output logic                     o_empty
);

  localparam logic [TAG_WIDTH-1:0] LastTag = TAG_WIDTH'(OPTN_NUM_TAGS - 1);
  localparam logic [CNT_WIDTH-1:0] NumTags = CNT_WIDTH'(OPTN_NUM_TAGS);

  // Explicit wrap so non-power-of-two tag counts work.
  function automatic logic [TAG_WIDTH-1:0] ptr_inc(input logic [TAG_WIDTH-1:0] ptr);
    return (ptr == LastTag) ? '0 : ptr + 1'b1;
  endfunction

  logic [TAG_WIDTH-1:0] entry_q [OPTN_NUM_TAGS];
  logic [TAG_WIDTH-1:0] entry_d [OPTN_NUM_TAGS];
  logic [TAG_WIDTH-1:0] head_q, head_d;
  logic [TAG_WIDTH-1:0] tail_q, tail_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;

  logic                     alloc_fire;
  logic                     release_fire;
  logic [OPTN_NUM_TAGS-1:0] head_onehot;

  assign o_alloc_valid = (count_q != '0);
  assign o_empty       = (count_q == '0);
  assign o_free_count  = count_q;
  assign o_alloc_tag   = entry_q[head_q];

  assign alloc_fire   = i_alloc_en & o_alloc_valid;
  // A release into a full list is illegal; dropping it keeps the ring consistent.
  assign release_fire = i_release_en & (count_q != NumTags);

  always_comb begin
    entry_d = entry_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (i_flush) begin
      for (int unsigned i = 0; i < OPTN_NUM_TAGS; i++) begin
        entry_d[i] = TAG_WIDTH'(i);
      end
      head_d  = '0;
      tail_d  = '0;
      count_d = NumTags;
    end else begin
      if (alloc_fire) begin
        head_d = ptr_inc(head_q);
      end
      if (release_fire) begin
        entry_d[tail_q] = i_release_tag;
        tail_d          = ptr_inc(tail_q);
      end
      count_d = count_q + CNT_WIDTH'(release_fire) - CNT_WIDTH'(alloc_fire);
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      for (int unsigned i = 0; i < OPTN_NUM_TAGS; i++) begin
        entry_q[i] <= TAG_WIDTH'(i);
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= NumTags;
    end else begin
      entry_q <= entry_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  procyon_binary2onehot #(
    .OPTN_ONEHOT_WIDTH(OPTN_NUM_TAGS)
  ) u_head_decode (
    .binary_i(o_alloc_tag),
    .onehot_o(head_onehot)
  );

  assign o_alloc_onehot = head_onehot & {OPTN_NUM_TAGS{o_alloc_valid}};

  release_when_full_a : assert property (
    @(posedge clk) disable iff (!n_rst) (i_release_en && !i_flush) |-> (count_q != NumTags)
  );

endmodule

// File: tb/tb_procyon_tag_freelist.sv
module tb_procyon_tag_freelist;

  localparam int NA = 32;
  localparam int NB = 6;

  logic clk;

  // DUT A: 32 tags
  logic        n_rst_a, flush_a, alloc_a, rel_a;
  logic [4:0]  rtag_a;
  logic        valid_a, empty_a;
  logic [4:0]  tag_a;
  logic [31:0] oh_a;
  logic [5:0]  cnt_a;

  // DUT B: 6 tags
  logic        n_rst_b, flush_b, alloc_b, rel_b;
  logic [2:0]  rtag_b;
  logic        valid_b, empty_b;
  logic [2:0]  tag_b;
  logic [5:0]  oh_b;
  logic [2:0]  cnt_b;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: FIFO of free tags, oldest first.
  int qa[$];
  int qb[$];
  int owned_a[$];

  procyon_tag_freelist #(.OPTN_NUM_TAGS(NA)) u_dut_a (
    .clk           (clk),
    .n_rst         (n_rst_a),
    .i_flush       (flush_a),
    .i_alloc_en    (alloc_a),
    .o_alloc_valid (valid_a),
    .o_alloc_tag   (tag_a),
    .o_alloc_onehot(oh_a),
    .i_release_en  (rel_a),
    .i_release_tag (rtag_a),
    .o_free_count  (cnt_a),
    .o_empty       (empty_a)
  );

  procyon_tag_freelist #(.OPTN_NUM_TAGS(NB)) u_dut_b (
    .clk           (clk),
    .n_rst         (n_rst_b),
    .i_flush       (flush_b),
    .i_alloc_en    (alloc_b),
    .o_alloc_valid (valid_b),
    .o_alloc_tag   (tag_b),
    .o_alloc_onehot(oh_b),
    .i_release_en  (rel_b),
    .i_release_tag (rtag_b),
    .o_free_count  (cnt_b),
    .o_empty       (empty_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock edge on DUT A with the given inputs; model updated from pre-edge state.
  task automatic drive_a(input bit rst, input bit fl, input bit al, input bit re, input int rt);
    int sz;
    n_rst_a = !rst;
    flush_a = fl;
    alloc_a = al;
    rel_a   = re;
    rtag_a  = 5'(rt);
    @(posedge clk);
    if (rst || fl) begin
      qa.delete();
      for (int i = 0; i < NA; i++) qa.push_back(i);
    end else begin
      sz = qa.size();
      if (al && sz != 0) void'(qa.pop_front());
      if (re && sz != NA) qa.push_back(rt);
    end
    #1;
    n_rst_a = 1'b1;
    flush_a = 1'b0;
    alloc_a = 1'b0;
    rel_a   = 1'b0;
  endtask

  task automatic drive_b(input bit rst, input bit al, input bit re, input int rt);
    int sz;
    n_rst_b = !rst;
    flush_b = 1'b0;
    alloc_b = al;
    rel_b   = re;
    rtag_b  = 3'(rt);
    @(posedge clk);
    if (rst) begin
      qb.delete();
      for (int i = 0; i < NB; i++) qb.push_back(i);
    end else begin
      sz = qb.size();
      if (al && sz != 0) void'(qb.pop_front());
      if (re && sz != NB) qb.push_back(rt);
    end
    #1;
    n_rst_b = 1'b1;
    alloc_b = 1'b0;
    rel_b   = 1'b0;
  endtask

  task automatic test_reset();
    drive_a(1, 0, 0, 0, 0);
    n_tests++;
    if (valid_a !== 1'b1) begin n_fail++; $display("FAIL reset_valid got %0b exp 1", valid_a); end
    n_tests++;
    if (tag_a !== 5'd0) begin n_fail++; $display("FAIL reset_tag got %0d exp 0", tag_a); end
    n_tests++;
    if (oh_a !== 32'h1) begin n_fail++; $display("FAIL reset_onehot got %h exp 1", oh_a); end
    n_tests++;
    if (cnt_a !== 6'd32) begin n_fail++; $display("FAIL reset_count got %0d exp 32", cnt_a); end
    n_tests++;
    if (empty_a !== 1'b0) begin n_fail++; $display("FAIL reset_empty got %0b exp 0", empty_a); end
  endtask

  task automatic test_alloc_all();
    for (int i = 0; i < NA; i++) begin
      n_tests++;
      if (tag_a !== 5'(i) || oh_a !== (32'h1 << i)) begin
        n_fail++;
        $display("FAIL alloc_seq got tag %0d oh %h exp tag %0d", tag_a, oh_a, i);
      end
      drive_a(0, 0, 1, 0, 0);
    end
    n_tests++;
    if (empty_a !== 1'b1 || valid_a !== 1'b0 || oh_a !== 32'h0 || cnt_a !== 6'd0) begin
      n_fail++;
      $display("FAIL alloc_empty got e%0b v%0b oh %h cnt %0d exp e1 v0 oh 0 cnt 0",
               empty_a, valid_a, oh_a, cnt_a);
    end
    drive_a(0, 0, 1, 0, 0);
    n_tests++;
    if (cnt_a !== 6'd0 || empty_a !== 1'b1) begin
      n_fail++;
      $display("FAIL alloc_when_empty got cnt %0d e%0b exp cnt 0 e1", cnt_a, empty_a);
    end
  endtask

  task automatic test_release_order();
    int rels[3] = '{7, 3, 9};
    for (int i = 0; i < 3; i++) drive_a(0, 0, 0, 1, rels[i]);
    n_tests++;
    if (cnt_a !== 6'd3) begin n_fail++; $display("FAIL release_count got %0d exp 3", cnt_a); end
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (tag_a !== 5'(rels[i])) begin
        n_fail++;
        $display("FAIL release_order got %0d exp %0d", tag_a, rels[i]);
      end
      drive_a(0, 0, 1, 0, 0);
    end
    n_tests++;
    if (cnt_a !== 6'd0) begin n_fail++; $display("FAIL release_drain got %0d exp 0", cnt_a); end
  endtask

  task automatic test_empty_simul();
    drive_a(0, 0, 1, 1, 5);
    n_tests++;
    if (cnt_a !== 6'd1 || tag_a !== 5'd5 || valid_a !== 1'b1) begin
      n_fail++;
      $display("FAIL empty_simul got cnt %0d tag %0d v%0b exp cnt 1 tag 5 v1",
               cnt_a, tag_a, valid_a);
    end
  endtask

  task automatic test_steady();
    drive_a(0, 1, 0, 0, 0);
    for (int i = 0; i < 22; i++) drive_a(0, 0, 1, 0, 0);
    n_tests++;
    if (cnt_a !== 6'd10 || tag_a !== 5'd22) begin
      n_fail++;
      $display("FAIL steady_setup got cnt %0d tag %0d exp cnt 10 tag 22", cnt_a, tag_a);
    end
    drive_a(0, 0, 1, 1, 4);
    n_tests++;
    if (cnt_a !== 6'd10 || tag_a !== 5'd23) begin
      n_fail++;
      $display("FAIL steady_simul got cnt %0d tag %0d exp cnt 10 tag 23", cnt_a, tag_a);
    end
    for (int i = 0; i < 9; i++) drive_a(0, 0, 1, 0, 0);
    n_tests++;
    if (cnt_a !== 6'd1 || tag_a !== 5'd4) begin
      n_fail++;
      $display("FAIL steady_tail got cnt %0d tag %0d exp cnt 1 tag 4", cnt_a, tag_a);
    end
  endtask

  task automatic test_flush();
    // One tag free (4), the rest held: flush with a concurrent alloc and release.
    drive_a(0, 1, 1, 1, 10);
    n_tests++;
    if (cnt_a !== 6'd32 || tag_a !== 5'd0) begin
      n_fail++;
      $display("FAIL flush_state got cnt %0d tag %0d exp cnt 32 tag 0", cnt_a, tag_a);
    end
    for (int i = 0; i < NA; i++) begin
      n_tests++;
      if (tag_a !== 5'(i)) begin n_fail++; $display("FAIL flush_seq got %0d exp %0d", tag_a, i); end
      drive_a(0, 0, 1, 0, 0);
    end
    drive_a(0, 0, 0, 1, 20);
    drive_a(0, 0, 0, 1, 11);
    drive_a(0, 0, 1, 1, 0);
    drive_a(1, 0, 1, 1, 5);
    n_tests++;
    if (cnt_a !== 6'd32 || tag_a !== 5'd0 || oh_a !== 32'h1) begin
      n_fail++;
      $display("FAIL rst_mid got cnt %0d tag %0d oh %h exp cnt 32 tag 0 oh 1", cnt_a, tag_a, oh_a);
    end
    for (int i = 0; i < NA; i++) begin
      n_tests++;
      if (tag_a !== 5'(i)) begin n_fail++; $display("FAIL rst_seq got %0d exp %0d", tag_a, i); end
      drive_a(0, 0, 1, 0, 0);
    end
  endtask

  task automatic test_random();
    // Every tag is held on entry.
    owned_a.delete();
    for (int i = 0; i < NA; i++) owned_a.push_back(i);
    for (int cyc = 0; cyc < 400; cyc++) begin
      bit al, re, fl, fires;
      int rt, idx, t;
      n_tests++;
      if (valid_a !== (qa.size() != 0) || cnt_a !== 6'(qa.size()) ||
          empty_a !== (qa.size() == 0)) begin
        n_fail++;
        $display("FAIL rand_status cyc %0d got v%0b cnt %0d e%0b exp cnt %0d",
                 cyc, valid_a, cnt_a, empty_a, qa.size());
      end
      if (qa.size() != 0) begin
        n_tests++;
        if (tag_a !== 5'(qa[0]) || oh_a !== (32'h1 << qa[0])) begin
          n_fail++;
          $display("FAIL rand_offer cyc %0d got tag %0d oh %h exp tag %0d",
                   cyc, tag_a, oh_a, qa[0]);
        end
      end else begin
        n_tests++;
        if (oh_a !== 32'h0) begin
          n_fail++;
          $display("FAIL rand_onehot_empty cyc %0d got %h exp 0", cyc, oh_a);
        end
      end
      al = ($urandom_range(0, 99) < 55);
      re = (owned_a.size() != 0) && ($urandom_range(0, 99) < 50);
      fl = ($urandom_range(0, 99) == 0);
      rt = 0;
      if (re) begin
        idx = $urandom_range(0, owned_a.size() - 1);
        rt  = owned_a[idx];
        owned_a.delete(idx);
      end
      fires = al && valid_a;
      t = int'(tag_a);
      if (fires && !fl) begin
        n_tests++;
        foreach (owned_a[k]) begin
          if (owned_a[k] == t) begin
            n_fail++;
            $display("FAIL rand_unique cyc %0d got tag %0d exp a free tag", cyc, t);
          end
        end
        owned_a.push_back(t);
      end
      drive_a(0, fl, al, re, rt);
      if (fl) owned_a.delete();
    end
  endtask

  task automatic test_n6();
    int owned_b[$];
    int t;
    drive_b(1, 0, 0, 0);
    n_tests++;
    if (cnt_b !== 3'd6 || tag_b !== 3'd0 || oh_b !== 6'h01) begin
      n_fail++;
      $display("FAIL n6_reset got cnt %0d tag %0d oh %h exp cnt 6 tag 0 oh 1", cnt_b, tag_b, oh_b);
    end
    for (int i = 0; i < 3; i++) begin
      owned_b.push_back(int'(tag_b));
      drive_b(0, 1, 0, 0);
    end
    for (int cyc = 0; cyc < 20; cyc++) begin
      n_tests++;
      if (cnt_b !== 3'(qb.size()) || tag_b !== 3'(qb[0]) || oh_b !== (6'h01 << qb[0])) begin
        n_fail++;
        $display("FAIL n6_churn cyc %0d got cnt %0d tag %0d oh %h exp cnt %0d tag %0d",
                 cyc, cnt_b, tag_b, oh_b, qb.size(), qb[0]);
      end
      t = int'(tag_b);
      n_tests++;
      foreach (owned_b[k]) begin
        if (owned_b[k] == t) begin
          n_fail++;
          $display("FAIL n6_unique cyc %0d got tag %0d exp a free tag", cyc, t);
        end
      end
      drive_b(0, 1, 1, owned_b.pop_front());
      owned_b.push_back(t);
    end
    n_tests++;
    if (cnt_b !== 3'd3) begin n_fail++; $display("FAIL n6_final_count got %0d exp 3", cnt_b); end
  endtask

  initial begin
    n_rst_a = 1'b0; flush_a = 1'b0; alloc_a = 1'b0; rel_a = 1'b0; rtag_a = '0;
    n_rst_b = 1'b0; flush_b = 1'b0; alloc_b = 1'b0; rel_b = 1'b0; rtag_b = '0;
    test_reset();
    test_alloc_all();
    test_release_order();
    test_empty_simul();
    test_steady();
    test_flush();
    test_random();
    test_n6();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
